// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM states, working-variable struct, round
// constants, initial hash value and the rotate helper.
package sha256_pkg;

  typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE, DONE} state_t;

  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;

  localparam work_t H0 = '{
    a: 32'h6a09e667, b: 32'hbb67ae85, c: 32'h3c6ef372, d: 32'ha54ff53a,
    e: 32'h510e527f, f: 32'h9b05688c, g: 32'h1f83d9ab, h: 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round over the working variables.
module sha256_round
  import sha256_pkg::*;
(
  input  work_t       cur,
  input  logic [31:0] w,
  input  logic [31:0] k,
  output work_t       nxt
);

  logic [31:0] sum1, sum0, ch, maj, t1, t2;

  assign sum1 = rotr(cur.e, 6) ^ rotr(cur.e, 11) ^ rotr(cur.e, 25);
  assign ch   = (cur.e & cur.f) ^ (~cur.e & cur.g);
  assign t1   = cur.h + sum1 + ch + k + w;
  assign sum0 = rotr(cur.a, 2) ^ rotr(cur.a, 13) ^ rotr(cur.a, 22);
  assign maj  = (cur.a & cur.b) ^ (cur.a & cur.c) ^ (cur.b & cur.c);
  assign t2   = sum0 + maj;

  assign nxt = '{a: t1 + t2, b: cur.a, c: cur.b, d: cur.c,
                 e: cur.d + t1, f: cur.e, g: cur.f, h: cur.g};

endmodule

// File: rtl/sha256_padded_hasher.sv
// Memory-mapped SHA-256: reads a word-aligned message, pads it on the fly,
// compresses block by block and writes the 8-word digest back to memory.
module sha256_padded_hasher
  import sha256_pkg::*;
#(
  parameter int MAX_WORDS = 64,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [15:0]       msg_words,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  state_t            state_q, state_d;
  logic [6:0]        cnt_q;
  logic [12:0]       blocks_left_q;
  logic [16:0]       base_q;
  logic              err_q;
  logic [15:0]       len_q;
  logic [ADDR_W-1:0] msg_base_q, out_base_q;
  work_t             hs_q, ws_q, ws_nxt;
  logic [31:0]       w_q [0:15];
  logic [16:0]       n_addr, n_dat;
  logic [31:0]       fill_word, sched_word;
  logic [12:0]       num_blocks;
  logic              bad_len, last_blk;

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] word_sel(input work_t s, input logic [2:0] i);
    case (i)
      3'd0:    return s.a;
      3'd1:    return s.b;
      3'd2:    return s.c;
      3'd3:    return s.d;
      3'd4:    return s.e;
      3'd5:    return s.f;
      3'd6:    return s.g;
      default: return s.h;
    endcase
  endfunction

  assign bad_len    = (msg_words == 16'd0) || (32'(msg_words) > MAX_WORDS);
  // Data bit, 64-bit length and rounding up to 512 bits collapse to (n+18)/16.
  assign num_blocks = 13'(({1'b0, msg_words} + 17'd18) >> 4);
  assign last_blk   = (blocks_left_q == 13'd1);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = bad_len ? DONE : READ;
      READ:    if (cnt_q == 7'd16) state_d = COMPUTE;
      COMPUTE: if (cnt_q == 7'd63) state_d = UPDATE;
      UPDATE:  state_d = last_blk ? WRITE : READ;
      WRITE:   if (cnt_q == 7'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      blocks_left_q <= '0;
      base_q        <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? 7'd0 : cnt_q + 7'd1;
      if (state_q == IDLE && start) begin
        blocks_left_q <= num_blocks;
        base_q        <= '0;
        err_q         <= bad_len;
      end
      if (state_q == UPDATE) begin
        blocks_left_q <= blocks_left_q - 13'd1;
        base_q        <= base_q + 17'd16;
      end
    end
  end

  // READ presents word cnt and captures word cnt-1 (one-cycle read latency).
  assign n_addr = base_q + 17'(cnt_q);
  assign n_dat  = n_addr - 17'd1;

  always_comb begin
    fill_word = 32'h0;
    if (n_dat < {1'b0, len_q})       fill_word = mem_read_data;
    else if (n_dat == {1'b0, len_q}) fill_word = 32'h8000_0000;
    else if (last_blk && n_dat[3:0] == 4'd15) fill_word = {11'd0, len_q, 5'd0};
  end

  assign sched_word = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];

  sha256_round u_round (
    .cur (ws_q),
    .w   (w_q[0]),
    .k   (K[cnt_q[5:0]]),
    .nxt (ws_nxt)
  );

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      len_q      <= msg_words;
      msg_base_q <= message_addr;
      out_base_q <= output_addr;
      hs_q       <= H0;
    end
    if (state_q == READ && cnt_q != 7'd0) begin
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= fill_word;
    end
    if (state_q == READ && cnt_q == 7'd16) ws_q <= hs_q;
    if (state_q == COMPUTE) begin
      ws_q <= ws_nxt;
      for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
      w_q[15] <= sched_word;
    end
    if (state_q == UPDATE) begin
      hs_q <= '{a: hs_q.a + ws_q.a, b: hs_q.b + ws_q.b, c: hs_q.c + ws_q.c, d: hs_q.d + ws_q.d,
                e: hs_q.e + ws_q.e, f: hs_q.f + ws_q.f, g: hs_q.g + ws_q.g, h: hs_q.h + ws_q.h};
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign error   = done & err_q;
  assign mem_clk = clk;

  always_comb begin
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = 32'h0;
    if (state_q == READ && cnt_q < 7'd16 && n_addr < {1'b0, len_q}) begin
      mem_addr = msg_base_q + ADDR_W'(n_addr);
    end else if (state_q == WRITE) begin
      mem_we         = 1'b1;
      mem_addr       = out_base_q + ADDR_W'(cnt_q);
      mem_write_data = word_sel(hs_q, cnt_q[2:0]);
    end
  end

endmodule

// File: tb/tb_sha256_padded_hasher.sv
// Directed bench for sha256_padded_hasher with a synchronous memory model and
// an independent SHA-256 reference for random messages.
module tb_sha256_padded_hasher;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] msg_words = '0;
  logic [15:0] message_addr = '0;
  logic [15:0] output_addr = '0;
  logic        busy, done, error, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] msgmem [0:65535];
  logic [31:0] outmem [0:65535];
  int          wr_total = 0;
  int          checks = 0;
  int          errors = 0;

  localparam logic [255:0] ABCD_DIGEST =
    256'h88d4266f_d4e6338d_13b845fc_f289579d_209c8978_23b9217d_a3e16193_6f031589;

  localparam logic [31:0] KT [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  always #5 clk = ~clk;

  sha256_padded_hasher #(.MAX_WORDS(64), .ADDR_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .msg_words      (msg_words),
    .message_addr   (message_addr),
    .output_addr    (output_addr),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .mem_clk        (mem_clk),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always @(posedge clk) begin
    mem_read_data <= msgmem[mem_addr];
    if (mem_we) begin
      outmem[mem_addr] <= mem_write_data;
      wr_total         <= wr_total + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] model(input int m, input logic [15:0] base);
    logic [31:0] pm [0:127];
    logic [31:0] w [0:63];
    logic [31:0] hv [0:7];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    int nb;
    nb = (32 * m + 65 + 511) / 512;
    for (int i = 0; i < 128; i++) pm[i] = 32'h0;
    for (int i = 0; i < m; i++) pm[i] = msgmem[16'(base + 16'(i))];
    pm[m] = 32'h8000_0000;
    pm[nb * 16 - 1] = 32'(m * 32);
    hv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int blk = 0; blk < nb; blk++) begin
      for (int t = 0; t < 16; t++) w[t] = pm[blk * 16 + t];
      for (int t = 16; t < 64; t++)
        w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
      e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
      for (int t = 0; t < 64; t++) begin
        t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
        t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
      hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    end
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  function automatic logic [255:0] dig(input logic [15:0] o);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], outmem[16'(o + 16'(i))]};
    return r;
  endfunction

  task automatic fill_random(input logic [15:0] base, input int m);
    for (int i = 0; i < m; i++) msgmem[16'(base + 16'(i))] = $urandom;
  endtask

  task automatic issue(input int m, input logic [15:0] ma, input logic [15:0] oa);
    @(negedge clk);
    msg_words    = 16'(m);
    message_addr = ma;
    output_addr  = oa;
    start        = 1'b1;
  endtask

  // mode 0: drop start after accept; 1: keep it high; 2: toggle it every cycle.
  task automatic wait_done(input int mode, input logic [15:0] oaddr, output int lat,
                           output int we_n, output int bad_we, output int addr_nz,
                           output int err_at_done);
    lat = 0; we_n = 0; bad_we = 0; addr_nz = 0; err_at_done = 0;
    @(posedge clk);
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clk);
      if (mode == 0) start = 1'b0;
      else if (mode == 2) start = ~start;
      if (mem_we === 1'b1) begin
        if (mem_addr !== 16'(oaddr + 16'(we_n))) bad_we = 1;
        we_n++;
      end
      if (mem_addr !== 16'h0) addr_nz = 1;
      if (done === 1'b1) begin
        lat = c;
        err_at_done = int'(error);
        break;
      end
    end
    if (mode != 1) start = 1'b0;
  endtask

  initial begin
    int lat, wen, bw, anz, ead, wr0;
    logic [255:0] exp_d;

    repeat (2) @(negedge clk);
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_error", 256'(error), 256'(0));
    chk("rst_mem_we", 256'(mem_we), 256'(0));
    chk("rst_mem_addr", 256'(mem_addr), 256'(0));
    chk("rst_wdata", 256'(mem_write_data), 256'(0));
    #6;
    chk("mem_clk_high", 256'(mem_clk), 256'(1));
    @(negedge clk);
    reset_n = 1'b1;

    msgmem[16'h0100] = 32'h61626364;
    issue(1, 16'h0100, 16'h0200);
    wait_done(0, 16'h0200, lat, wen, bw, anz, ead);
    chk("abcd_latency", 256'(lat), 256'(91));
    chk("abcd_we_count", 256'(wen), 256'(8));
    chk("abcd_we_addr", 256'(bw), 256'(0));
    chk("abcd_error", 256'(ead), 256'(0));
    chk("abcd_digest", dig(16'h0200), ABCD_DIGEST);

    fill_random(16'h0300, 13);
    exp_d = model(13, 16'h0300);
    issue(13, 16'h0300, 16'h0210);
    wait_done(0, 16'h0210, lat, wen, bw, anz, ead);
    chk("w13_latency", 256'(lat), 256'(91));
    chk("w13_digest", dig(16'h0210), exp_d);

    fill_random(16'h0400, 14);
    exp_d = model(14, 16'h0400);
    issue(14, 16'h0400, 16'h0220);
    wait_done(2, 16'h0220, lat, wen, bw, anz, ead);
    chk("w14_latency", 256'(lat), 256'(173));
    chk("w14_digest", dig(16'h0220), exp_d);

    fill_random(16'h0500, 20);
    exp_d = model(20, 16'h0500);
    issue(20, 16'h0500, 16'h0230);
    wait_done(0, 16'h0230, lat, wen, bw, anz, ead);
    chk("w20_latency", 256'(lat), 256'(173));
    chk("w20_we_count", 256'(wen), 256'(8));
    chk("w20_we_addr", 256'(bw), 256'(0));
    chk("w20_digest", dig(16'h0230), exp_d);

    fill_random(16'h0600, 64);
    exp_d = model(64, 16'h0600);
    issue(64, 16'h0600, 16'h0238);
    wait_done(0, 16'h0238, lat, wen, bw, anz, ead);
    chk("w64_latency", 256'(lat), 256'(419));
    chk("w64_error", 256'(ead), 256'(0));
    chk("w64_digest", dig(16'h0238), exp_d);

    wr0 = wr_total;
    issue(0, 16'h0123, 16'h0240);
    wait_done(0, 16'h0240, lat, wen, bw, anz, ead);
    chk("len0_latency", 256'(lat), 256'(1));
    chk("len0_error", 256'(ead), 256'(1));
    chk("len0_we", 256'(wen), 256'(0));
    chk("len0_addr", 256'(anz), 256'(0));

    issue(65, 16'h0123, 16'h0248);
    wait_done(0, 16'h0248, lat, wen, bw, anz, ead);
    chk("len65_latency", 256'(lat), 256'(1));
    chk("len65_error", 256'(ead), 256'(1));
    chk("len65_we", 256'(wen), 256'(0));
    chk("len65_addr", 256'(anz), 256'(0));
    @(negedge clk);
    chk("err_pulse_len", 256'({done, error}), 256'(0));
    chk("err_no_writes", 256'(wr_total), 256'(wr0));

    issue(1, 16'h0100, 16'h0250);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (47) @(negedge clk);
    chk("mid_busy", 256'(busy), 256'(1));
    wr0 = wr_total;
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_done_err", 256'({done, error}), 256'(0));
    chk("mid_rst_mem", 256'({mem_we, mem_addr, mem_write_data}), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("mid_no_writes", 256'(wr_total), 256'(wr0));
    chk("mid_idle", 256'(busy), 256'(0));
    issue(1, 16'h0100, 16'h0260);
    wait_done(0, 16'h0260, lat, wen, bw, anz, ead);
    chk("post_rst_latency", 256'(lat), 256'(91));
    chk("post_rst_digest", dig(16'h0260), ABCD_DIGEST);

    fill_random(16'h0700, 20);
    exp_d = model(20, 16'h0700);
    issue(20, 16'h0700, 16'h0270);
    wait_done(1, 16'h0270, lat, wen, bw, anz, ead);
    chk("held_latency", 256'(lat), 256'(173));
    chk("held_digest", dig(16'h0270), exp_d);
    @(negedge clk);
    chk("held_idle_gap", 256'(busy), 256'(0));
    wait_done(1, 16'h0270, lat, wen, bw, anz, ead);
    start = 1'b0;
    chk("held2_latency", 256'(lat), 256'(173));
    chk("held2_we_count", 256'(wen), 256'(8));
    chk("held2_digest", dig(16'h0270), exp_d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
